// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller between EX and the unsigned iterative
// divider div_u. Handles RISC-V DIV/DIVU/REM/REMU sign handling, the
// divide-by-zero and signed-overflow shortcuts, and a one-entry result cache
// so that the complementary result of the last division comes back without
// re-running the divider.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a request; special cases and cache hits resolve here
// S_RUN  | du_start held high, waiting for du_done
// S_RESP | div_valid pulse; du_start low so the divider sees a fresh edge
module div_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          CACHE_EN   = 1'b1
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  div_req,
  output logic                  div_ready,
  input  logic [1:0]            div_op,
  input  logic [DATA_WIDTH-1:0] div_rs1,
  input  logic [DATA_WIDTH-1:0] div_rs2,
  input  logic                  div_kill,
  output logic                  div_valid,
  output logic [DATA_WIDTH-1:0] div_result,
  output logic                  du_start,
  output logic [DATA_WIDTH-1:0] du_src1,
  output logic [DATA_WIDTH-1:0] du_src2,
  input  logic                  du_done,
  input  logic [DATA_WIDTH-1:0] du_quot,
  input  logic [DATA_WIDTH-1:0] du_rem
);

  localparam int unsigned           MSB      = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  start_q, start_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d;
  logic [DATA_WIDTH-1:0] src2_q, src2_d;
  logic                  sel_rem_q, sel_rem_d;
  logic                  sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  cache_vld_q, cache_vld_d;
  logic [DATA_WIDTH-1:0] cache_rs1_q, cache_rs1_d;
  logic [DATA_WIDTH-1:0] cache_rs2_q, cache_rs2_d;
  logic                  cache_sgn_q, cache_sgn_d;
  logic [DATA_WIDTH-1:0] cache_quot_q, cache_quot_d;
  logic [DATA_WIDTH-1:0] cache_rem_q, cache_rem_d;

  logic                  accept;
  logic                  sgn_in;
  logic                  rs1_neg;
  logic                  rs2_neg;
  logic [DATA_WIDTH-1:0] mag1;
  logic [DATA_WIDTH-1:0] mag2;
  logic                  div_zero;
  logic                  ovf;
  logic                  special;
  logic [DATA_WIDTH-1:0] spec_res;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_res;
  logic [DATA_WIDTH-1:0] quot_fix;
  logic [DATA_WIDTH-1:0] rem_fix;

  assign accept   = div_req && ready_q && !div_kill;
  assign sgn_in   = ~div_op[0];
  assign rs1_neg  = sgn_in & div_rs1[MSB];
  assign rs2_neg  = sgn_in & div_rs2[MSB];
  assign mag1     = rs1_neg ? -div_rs1 : div_rs1;
  assign mag2     = rs2_neg ? -div_rs2 : div_rs2;

  // Shortcut results: x/0 gives all ones (rem = dividend); MIN/-1 gives MIN (rem = 0)
  assign div_zero = (div_rs2 == ZERO);
  assign ovf      = sgn_in && (div_rs1 == MIN_NEG) && (div_rs2 == ALL_ONES);
  assign special  = div_zero || ovf;
  assign spec_res = div_zero ? (div_op[1] ? div_rs1 : ALL_ONES)
                             : (div_op[1] ? ZERO    : div_rs1);

  assign hit      = CACHE_EN && cache_vld_q && (cache_rs1_q == div_rs1) &&
                    (cache_rs2_q == div_rs2) && (cache_sgn_q == sgn_in);
  assign hit_res  = div_op[1] ? cache_rem_q : cache_quot_q;

  assign quot_fix = neg_quot_q ? -du_quot : du_quot;
  assign rem_fix  = neg_rem_q  ? -du_rem  : du_rem;

  // Next-state and registered-output computation; kill overrides everything
  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    valid_d      = 1'b0;
    result_d     = result_q;
    start_d      = start_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    sel_rem_d    = sel_rem_q;
    sgn_d        = sgn_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    neg_quot_d   = neg_quot_q;
    neg_rem_d    = neg_rem_q;
    cache_vld_d  = cache_vld_q;
    cache_rs1_d  = cache_rs1_q;
    cache_rs2_d  = cache_rs2_q;
    cache_sgn_d  = cache_sgn_q;
    cache_quot_d = cache_quot_q;
    cache_rem_d  = cache_rem_q;

    if (div_kill) begin
      state_d = S_IDLE;
      ready_d = 1'b1;
      start_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sel_rem_d  = div_op[1];
            sgn_d      = sgn_in;
            rs1_d      = div_rs1;
            rs2_d      = div_rs2;
            neg_quot_d = rs1_neg ^ rs2_neg;
            neg_rem_d  = rs1_neg;
            ready_d    = 1'b0;
            if (special) begin
              result_d = spec_res;
              valid_d  = 1'b1;
              state_d  = S_RESP;
            end else if (hit) begin
              result_d = hit_res;
              valid_d  = 1'b1;
              state_d  = S_RESP;
            end else begin
              src1_d  = mag1;
              src2_d  = mag2;
              start_d = 1'b1;
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (du_done) begin
            result_d     = sel_rem_q ? rem_fix : quot_fix;
            cache_vld_d  = 1'b1;
            cache_rs1_d  = rs1_q;
            cache_rs2_d  = rs2_q;
            cache_sgn_d  = sgn_q;
            cache_quot_d = quot_fix;
            cache_rem_d  = rem_fix;
            start_d      = 1'b0;
            valid_d      = 1'b1;
            state_d      = S_RESP;
          end
        end
        S_RESP: begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
        default: begin
          ready_d = 1'b1;
          start_d = 1'b0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, registered outputs and cache storage
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      result_q     <= ZERO;
      start_q      <= 1'b0;
      src1_q       <= ZERO;
      src2_q       <= ZERO;
      sel_rem_q    <= 1'b0;
      sgn_q        <= 1'b0;
      rs1_q        <= ZERO;
      rs2_q        <= ZERO;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      cache_vld_q  <= 1'b0;
      cache_rs1_q  <= ZERO;
      cache_rs2_q  <= ZERO;
      cache_sgn_q  <= 1'b0;
      cache_quot_q <= ZERO;
      cache_rem_q  <= ZERO;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      result_q     <= result_d;
      start_q      <= start_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      sel_rem_q    <= sel_rem_d;
      sgn_q        <= sgn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      neg_quot_q   <= neg_quot_d;
      neg_rem_q    <= neg_rem_d;
      cache_vld_q  <= cache_vld_d;
      cache_rs1_q  <= cache_rs1_d;
      cache_rs2_q  <= cache_rs2_d;
      cache_sgn_q  <= cache_sgn_d;
      cache_quot_q <= cache_quot_d;
      cache_rem_q  <= cache_rem_d;
    end
  end

  assign div_ready  = ready_q;
  // A flush in the response cycle must swallow the pulse in that same cycle
  assign div_valid  = valid_q & ~div_kill;
  assign div_result = result_q;
  assign du_start   = start_q;
  assign du_src1    = src1_q;
  assign du_src2    = src2_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Testbench for div_ctrl: table of directed vectors, hand-written kill/reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_div_ctrl;

  logic        cpu_clk;
  logic        cpu_rstn;
  logic        div_req;
  logic        div_ready;
  logic [1:0]  div_op;
  logic [31:0] div_rs1;
  logic [31:0] div_rs2;
  logic        div_kill;
  logic        div_valid;
  logic [31:0] div_result;
  logic        du_start;
  logic [31:0] du_src1;
  logic [31:0] du_src2;
  logic        du_done;
  logic [31:0] du_quot;
  logic [31:0] du_rem;

  int tests = 0;
  int fails = 0;

  // divider model: done after du_lat cycles of du_start high
  int   du_lat = 33;
  int   du_cnt;
  logic spur_done;

  // reference-model cache of the last divider-path operands
  bit          m_vld;
  logic [31:0] m_a, m_b;
  bit          m_sgn;
  logic [31:0] last_res;

  div_ctrl #(.DATA_WIDTH(32), .CACHE_EN(1'b1)) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .div_req   (div_req),
    .div_ready (div_ready),
    .div_op    (div_op),
    .div_rs1   (div_rs1),
    .div_rs2   (div_rs2),
    .div_kill  (div_kill),
    .div_valid (div_valid),
    .div_result(div_result),
    .du_start  (du_start),
    .du_src1   (du_src1),
    .du_src2   (du_src2),
    .du_done   (du_done),
    .du_quot   (du_quot),
    .du_rem    (du_rem)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) du_cnt <= 0;
    else           du_cnt <= du_start ? du_cnt + 1 : 0;
  end

  assign du_done = (du_start && (du_cnt == du_lat - 1)) || spur_done;

  always_comb begin
    du_quot = 32'hFFFF_FFFF;
    du_rem  = du_src1;
    if (du_src2 != 32'd0) begin
      du_quot = du_src1 / du_src2;
      du_rem  = du_src1 % du_src2;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    bit sg;
    sg = !op[0];
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (sb == 0) begin
      q = -1;
      r = sa;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] x, input bit sg);
    return (sg && x[31]) ? -x : x;
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic bit is_hit(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b);
    return m_vld && m_a == a && m_b == b && m_sgn == !op[0];
  endfunction

  // one request from a falling edge; returns what the DUT did until div_valid
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int nstart,
                       output logic [31:0] s1, output logic [31:0] s2,
                       output bit vld_after, output bit rdy_bad);
    res = '0; lat = 0; nstart = 0; s1 = '0; s2 = '0; vld_after = 0; rdy_bad = 0;
    div_op = op; div_rs1 = a; div_rs2 = b; div_req = 1'b1;
    @(negedge cpu_clk);
    div_req = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (div_valid) begin
        res = div_result;
        lat = k;
        break;
      end
      if (div_ready) rdy_bad = 1;
      if (du_start) begin
        if (nstart == 0) begin
          s1 = du_src1;
          s2 = du_src2;
        end
        nstart++;
      end
      @(negedge cpu_clk);
    end
    @(negedge cpu_clk);
    vld_after = div_valid;
  endtask

  task automatic run_checked(input string tag, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_res,
                             input int exp_lat);
    logic [31:0] res, s1, s2;
    int lat, ns;
    bit va, rb, sg;
    sg = !op[0];
    do_op(op, a, b, res, lat, ns, s1, s2, va, rb);
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " du_start cycles"}, ns, (exp_lat == 1) ? 0 : exp_lat - 1);
    check({tag, " valid pulse width"}, va, 0);
    check({tag, " ready while busy"}, rb, 0);
    if (exp_lat != 1) begin
      check({tag, " du_src1"}, s1, mag(a, sg));
      check({tag, " du_src2"}, s2, mag(b, sg));
      m_vld = 1; m_a = a; m_b = b; m_sgn = sg;
    end
    last_res = res;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd7;
      3: return 32'hFFFF_FFFF;
      4: return 32'h8000_0000;
      5: return 32'hFFFF_FF9C;
      6: return $urandom;
      default: return $urandom_range(1, 1000);
    endcase
  endfunction

  initial begin
    logic [31:0] ra, rb_v, rexp;
    logic [1:0]  rop;
    int          rlat;
    bit          saw;

    tbl[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         34};
    tbl[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1};
    tbl[2]  = '{2'b00, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34};
    tbl[3]  = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1};
    tbl[4]  = '{2'b00, 32'd20,         32'd0,          32'hFFFF_FFFF,  1};
    tbl[5]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1};
    tbl[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    tbl[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    tbl[8]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    tbl[9]  = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    tbl[10] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34};
    tbl[11] = '{2'b11, 32'hFFFF_FF9C,  32'd7,          32'd2,          34};
    tbl[12] = '{2'b01, 32'hFFFF_FF9C,  32'd7,          32'h2492_4916,  1};
    tbl[13] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    tbl[14] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1};
    tbl[15] = '{2'b11, 32'd0,          32'd5,          32'd0,          34};

    cpu_rstn = 1'b0; div_req = 1'b0; div_op = 2'b00; div_rs1 = '0; div_rs2 = '0;
    div_kill = 1'b0; spur_done = 1'b0; m_vld = 0; m_a = '0; m_b = '0; m_sgn = 0;
    last_res = '0;

    #12;
    check("reset div_ready", div_ready, 1);
    check("reset div_valid", div_valid, 0);
    check("reset div_result", div_result, 0);
    check("reset du_start", du_start, 0);
    check("reset du_src1", du_src1, 0);
    check("reset du_src2", du_src2, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);

    du_lat = 33;
    for (int i = 0; i < 16; i++)
      run_checked($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].lat);

    // kill in IDLE together with a request blocks the accept
    div_op = 2'b01; div_rs1 = 32'd50; div_rs2 = 32'd5; div_req = 1'b1; div_kill = 1'b1;
    @(negedge cpu_clk);
    check("idle kill ready", div_ready, 1);
    check("idle kill du_start", du_start, 0);
    check("idle kill valid", div_valid, 0);
    div_req = 1'b0; div_kill = 1'b0;
    @(negedge cpu_clk);

    // kill in RESP swallows the pulse in that cycle
    div_op = 2'b00; div_rs1 = 32'd9; div_rs2 = 32'd0; div_req = 1'b1;
    @(negedge cpu_clk);
    div_req = 1'b0;
    div_kill = 1'b1;
    #1;
    check("resp kill valid", div_valid, 0);
    @(negedge cpu_clk);
    div_kill = 1'b0;
    check("resp kill ready", div_ready, 1);
    check("resp kill valid after", div_valid, 0);

    // kill 10 cycles after accept during the divider run
    div_op = 2'b01; div_rs1 = 32'hFFFF_FFFF; div_rs2 = 32'd3; div_req = 1'b1;
    @(negedge cpu_clk);
    div_req = 1'b0;
    repeat (9) @(negedge cpu_clk);
    check("run kill start before", du_start, 1);
    div_kill = 1'b1;
    @(negedge cpu_clk);
    div_kill = 1'b0;
    check("run kill du_start", du_start, 0);
    check("run kill ready", div_ready, 1);
    saw = 0;
    for (int k = 0; k < 40; k++) begin
      if (div_valid) saw = 1;
      @(negedge cpu_clk);
    end
    check("run kill no valid", saw, 0);
    run_checked("remu after kill", 2'b11, 32'hFFFF_FFFF, 32'd3, 32'd0, 34);
    run_checked("divu hit after kill", 2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 1);

    // kill in the same cycle as du_done wins: no capture, no cache write
    div_op = 2'b01; div_rs1 = 32'd77; div_rs2 = 32'd5; div_req = 1'b1;
    @(negedge cpu_clk);
    div_req = 1'b0;
    repeat (32) @(negedge cpu_clk);
    check("done kill start", du_start, 1);
    div_kill = 1'b1;
    @(negedge cpu_clk);
    div_kill = 1'b0;
    check("done kill valid", div_valid, 0);
    check("done kill ready", div_ready, 1);
    check("done kill result held", div_result, last_res);
    saw = 0;
    for (int k = 0; k < 4; k++) begin
      if (div_valid) saw = 1;
      @(negedge cpu_clk);
    end
    check("done kill no valid", saw, 0);
    run_checked("remu after done kill", 2'b11, 32'd77, 32'd5, 32'd2, 34);

    // du_done outside RUN is ignored
    spur_done = 1'b1;
    @(negedge cpu_clk);
    spur_done = 1'b0;
    @(negedge cpu_clk);
    check("idle done valid", div_valid, 0);
    check("idle done ready", div_ready, 1);
    check("idle done result", div_result, last_res);

    // reset mid-run invalidates the cache
    run_checked("divu pre reset", 2'b01, 32'd1000, 32'd10, 32'd100, 34);
    div_op = 2'b01; div_rs1 = 32'd500; div_rs2 = 32'd5; div_req = 1'b1;
    @(negedge cpu_clk);
    div_req = 1'b0;
    repeat (4) @(negedge cpu_clk);
    cpu_rstn = 1'b0;
    #1;
    check("midrst ready", div_ready, 1);
    check("midrst valid", div_valid, 0);
    check("midrst result", div_result, 0);
    check("midrst du_start", du_start, 0);
    check("midrst du_src1", du_src1, 0);
    check("midrst du_src2", du_src2, 0);
    m_vld = 0;
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    @(negedge cpu_clk);
    run_checked("divu post reset", 2'b01, 32'd1000, 32'd10, 32'd100, 34);

    // randomized operations with varying divider latency
    ra = 32'd1000; rb_v = 32'd10;
    for (int i = 0; i < 50; i++) begin
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        ra = pick();
        rb_v = pick();
      end
      du_lat = $urandom_range(1, 40);
      rexp = ref_res(rop, ra, rb_v);
      rlat = (is_special(rop, ra, rb_v) || is_hit(rop, ra, rb_v)) ? 1 : du_lat + 1;
      run_checked($sformatf("rnd%0d op%0d 0x%0h/0x%0h", i, rop, ra, rb_v),
                  rop, ra, rb_v, rexp, rlat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller between the execute stage and the unsigned iterative divider `div_u`.
- Implements RISC-V DIV/DIVU/REM/REMU:
  - accepts requests through a ready/valid handshake;
  - converts signed operands to magnitudes and drives the divider's start/operand inputs;
  - applies sign correction to the result;
  - resolves divide-by-zero and signed overflow without invoking the divider.
- A one-entry result cache returns the complementary result (e.g. REM after DIV on the same operands) without re-running the divider.

Parameters:
- DATA_WIDTH, 32: operand/result width; must equal the divider's width.
- CACHE_EN, 1: 1 enables the one-entry operand/result cache; 0 means every request misses.

Ports:
- cpu_clk  in  1  core clock
- cpu_rstn  in  1  asynchronous active-low reset
- div_req  in  1  request valid from EX
- div_ready  out  1  controller can accept a request
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- div_rs1  in  DATA_WIDTH  dividend
- div_rs2  in  DATA_WIDTH  divisor
- div_kill  in  1  pipeline flush; aborts the current operation
- div_valid  out  1  one-cycle pulse: div_result is valid
- div_result  out  DATA_WIDTH  final signed/unsigned result
- du_start  out  1  to divider start; held high for the whole operation
- du_src1  out  DATA_WIDTH  dividend magnitude to divider
- du_src2  out  DATA_WIDTH  divisor magnitude to divider
- du_done  in  1  divider done
- du_quot  in  DATA_WIDTH  divider quotient
- du_rem  in  DATA_WIDTH  divider remainder

Behaviour:

Reset (cpu_rstn, asynchronous, active-low; clock cpu_clk):
- state=IDLE; div_ready=1; div_valid=0; div_result=0.
- du_start=0; du_src1=du_src2=0.
- Cache valid bit cleared.

Signedness and operand rules:
- Accept occurs when div_req && div_ready && !div_kill; div_ready=1 only in IDLE.
- On accept, register op, rs1, rs2 and signed = !div_op[0].
- Magnitudes: if signed and msb set, the two's-complement negation is used; otherwise the raw value.
- neg_q = signed & (rs1 msb ^ rs2 msb).
- neg_r = signed & rs1 msb.

Special cases (resolved on accept, no divider use):
- rs2==0: quotient = all ones; remainder = rs1.
- signed & rs1==100..0 & rs2==all ones: quotient = rs1; remainder = 0.

Cache hit (CACHE_EN=1):
- Hit requires cache valid, rs1 and rs2 equal to the stored operands, and signed equal to the stored signedness.
- The stored quotient or remainder is selected by op[1].

State machine IDLE / RUN / RESP:
- IDLE:
  - on accept with special case or hit: go to RESP, with the result registered.
  - on other accept: load du_src1/du_src2 with the magnitudes, go to RUN.
- RUN:
  - du_start=1; du_src1/du_src2 held stable.
  - du_done is sampled only in RUN, ignored in all other states.
  - When du_done=1: correct the quotient by neg_q (negate) and the remainder by neg_r.
  - Register the selected result, write the cache (operands, signedness, both corrected results, valid=1), go to RESP.
- RESP:
  - div_valid=1 for exactly one cycle; du_start=0; go to IDLE.

Timing and output holding:
- du_start is low in IDLE and RESP, so there are at least 2 low cycles between divider operations and the divider sees a fresh rising edge per operation.
- Latency from the accept cycle:
  - special case or hit: div_valid in the next cycle;
  - divider path: 2 cycles after the accept cycle plus the cycles spent in RUN waiting for du_done; the full 32-step division gives div_valid 34 cycles after accept.
- div_result holds its value until the next result is registered.

div_kill:
- Any state: go to IDLE next cycle; du_start=0 next cycle; no div_valid; cache not written.
- Kill in RESP suppresses div_valid in that same cycle.
- Kill in IDLE with div_req blocks the accept.
- Kill in the RUN cycle where du_done=1 takes priority: no capture.

Other rules:
- div_req while busy is ignored; the requester holds its request until div_ready.
- Special-case results do not update the cache.
- Reset mid-operation: immediate return to reset values; the cache is invalidated.

Test Plan:
- DIVU rs1=100, rs2=7 after reset -> du_start high for 33 cycles; div_valid 34 cycles after accept, div_result=14; div_ready low during the operation.
- REMU rs1=100, rs2=7 immediately after the previous case -> cache hit, du_start stays 0, div_valid next cycle, div_result=2.
- DIV rs1=-100 (0xFFFFFF9C), rs2=7 -> du_src1=100, du_src2=7; div_result=0xFFFFFFF2 (-14). A following REM on the same operands gives 0xFFFFFFFE (-2) from the cache.
- Edge cases, each resolving next cycle with no du_start:
  - DIV rs2=0 -> div_result=0xFFFFFFFF;
  - REM rs1=5, rs2=0 -> div_result=5;
  - DIV 0x80000000 / 0xFFFFFFFF -> div_result=0x80000000;
  - REM of the same overflow operands -> div_result=0.
- DIVU 0xFFFFFFFF / 3 with div_kill asserted 10 cycles after accept:
  - du_start drops next cycle, no div_valid, div_ready returns;
  - a following REMU 0xFFFFFFFF / 3 misses the cache and returns 0 after the full latency.
- Assert cpu_rstn low mid-RUN -> all outputs at reset values immediately. A DIVU with the previous operands then misses the cache and produces the correct result.
